// File: rtl/frame_write_buffer.sv
// Stream-to-memory write sequencer: buffers a valid/ready pixel stream in a small FIFO and
// issues one sequential, handshaked write per word for a frame starting at a programmable address.
module frame_write_buffer #(
    parameter int FIFO_DEPTH = 16,
    parameter int FIFO_AW    = 4,
    parameter int ADDR_STEP  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [19:0] base_addr,
    input  logic [19:0] frame_words,
    input  logic        iValid,
    input  logic [31:0] iData,
    output logic        oReady,
    output logic [19:0] write_addr,
    output logic [31:0] oData,
    output logic        write,
    input  logic        write_done,
    output logic        busy,
    output logic        frame_done
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state_q, state_d;
    logic [19:0]          addr_q, addr_d;
    logic [19:0]          wr_left_q, wr_left_d;
    logic [19:0]          in_left_q, in_left_d;
    logic [19:0]          write_addr_q, write_addr_d;
    logic                 write_q, write_d;
    logic [31:0]          odata_q;
    logic [FIFO_AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]     count_q, count_d;
    logic [31:0]          mem [FIFO_DEPTH];

    logic fifo_full, fifo_empty, push, load, accept;

    assign fifo_full  = (count_q == (FIFO_AW+1)'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign oReady     = (state_q == RUN) && !fifo_full && (in_left_q != 20'd0);
    assign push       = iValid && oReady;
    assign accept     = write_q && write_done;
    // The output register reloads whenever it is free or being freed this cycle.
    assign load       = (state_q == RUN) && !fifo_empty && (!write_q || write_done);

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        wr_left_d    = wr_left_q;
        in_left_d    = in_left_q;
        write_addr_d = write_addr_q;
        write_d      = write_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (frame_words != 20'd0) begin
                        addr_d    = base_addr;
                        wr_left_d = frame_words;
                        in_left_d = frame_words;
                        state_d   = RUN;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            RUN: begin
                if (push) begin
                    in_left_d = in_left_q - 20'd1;
                end
                if (accept) begin
                    addr_d    = addr_q + 20'(ADDR_STEP);
                    wr_left_d = wr_left_q - 20'd1;
                    if (wr_left_q == 20'd1) begin
                        state_d = DONE;
                    end
                end
                // addr_d already points past an accepted write, so a back-to-back load gets the next address.
                if (load) begin
                    write_addr_d = addr_d;
                    write_d      = 1'b1;
                end else if (accept) begin
                    write_d = 1'b0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + FIFO_AW'(1) : wr_ptr_q;
        rd_ptr_d = load ? rd_ptr_q + FIFO_AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !load) begin
            count_d = count_q + (FIFO_AW+1)'(1);
        end else if (!push && load) begin
            count_d = count_q - (FIFO_AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            wr_left_q    <= '0;
            in_left_q    <= '0;
            write_addr_q <= '0;
            write_q      <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wr_left_q    <= wr_left_d;
            in_left_q    <= in_left_d;
            write_addr_q <= write_addr_d;
            write_q      <= write_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    // Storage array has no reset so it maps onto block RAM; the read port is the output data register.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= iData;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            odata_q <= '0;
        end else if (load) begin
            odata_q <= mem[rd_ptr_q];
        end
    end

    assign write_addr = write_addr_q;
    assign oData      = odata_q;
    assign write      = write_q;
    assign busy       = (state_q == RUN);
    assign frame_done = (state_q == DONE);

endmodule

// File: tb/tb_frame_write_buffer.sv
// Directed bench for frame_write_buffer: table of frames with hand-computed end addresses and
// completion cycles, plus a hand-written reset-mid-frame sequence.
module tb_frame_write_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [19:0] base_addr;
    logic [19:0] frame_words;
    logic        iValid;
    logic [31:0] iData;
    logic        oReady;
    logic [19:0] write_addr;
    logic [31:0] oData;
    logic        write;
    logic        write_done;
    logic        busy;
    logic        frame_done;

    int tests = 0;
    int fails = 0;

    frame_write_buffer #(.FIFO_DEPTH(16), .FIFO_AW(4), .ADDR_STEP(4)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .frame_words(frame_words), .iValid(iValid), .iData(iData), .oReady(oReady),
        .write_addr(write_addr), .oData(oData), .write(write), .write_done(write_done),
        .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [19:0] base;
        logic [19:0] words;
        logic [31:0] dbase;
        int          offer;
        int          stall_idx;
        int          stall_len;
        bit          busy_start;
        bit          expect_full;
        logic [19:0] exp_last;
        int          exp_done;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Runs one frame; start is driven on iteration 0 and outputs are sampled on falling edges.
    task automatic run_frame(input string tag, input vec_t v);
        int fed, acc, stall_cnt, done_it, first_w_it, max_occ, occ;
        logic        held;
        logic [19:0] held_a, last_a, exp_a;
        logic [31:0] held_d;
        fed = 0; acc = 0; stall_cnt = 0; done_it = -1; first_w_it = -1; max_occ = 0;
        held = 1'b0; held_a = '0; held_d = '0; last_a = '0;
        for (int it = 0; it < 300 && done_it < 0; it++) begin
            @(negedge clk);
            if (frame_done) done_it = it;
            if (write && first_w_it < 0) first_w_it = it;
            if (held) begin
                check({tag, "_hold_addr"}, write_addr, held_a);
                check({tag, "_hold_data"}, oData, held_d);
            end
            if (it == 1) check({tag, "_busy_t1"}, busy, v.words != 0);
            if (busy) begin
                occ = fed - acc - int'(write);
                if (occ > max_occ) max_occ = occ;
                if (fed >= int'(v.words)) check({tag, "_ready_end"}, oReady, 1'b0);
                else check({tag, "_ready_occ"}, oReady, occ < 16);
            end else begin
                check({tag, "_idle_out"}, {oReady, write}, 2'b00);
            end
            if (done_it >= 0) break;
            start       = (it == 0);
            base_addr   = v.base;
            frame_words = v.words;
            if (v.busy_start && it == 3) begin
                start       = 1'b1;
                base_addr   = ~v.base;
                frame_words = 20'd5;
            end
            iValid     = (fed < v.offer);
            iData      = v.dbase + 32'(fed);
            write_done = !(acc == v.stall_idx && stall_cnt < v.stall_len);
            held = write && !write_done;
            if (held) begin
                held_a = write_addr;
                held_d = oData;
                stall_cnt++;
            end
            if (iValid && oReady) fed++;
            if (write && write_done) begin
                exp_a = v.base + 20'(acc * 4);
                check($sformatf("%s_w%0d_addr", tag, acc), write_addr, exp_a);
                check($sformatf("%s_w%0d_data", tag, acc), oData, v.dbase + 32'(acc));
                last_a = write_addr;
                acc++;
            end
        end
        start = 1'b0; iValid = 1'b0; write_done = 1'b0;
        check({tag, "_done_cycle"}, done_it, v.exp_done);
        check({tag, "_write_count"}, acc, v.words);
        check({tag, "_input_count"}, fed, v.words);
        if (v.words != 0) begin
            check({tag, "_last_addr"}, last_a, v.exp_last);
            check({tag, "_first_write"}, first_w_it, 3);
        end
        if (v.expect_full) check({tag, "_fifo_full"}, max_occ, 16);
        @(negedge clk);
        check({tag, "_after_done"}, {busy, frame_done}, 2'b00);
    endtask

    initial begin
        int acc;
        vecs[0] = '{20'h00100, 20'd4,  32'hA0,   4,  -1, 0,  1'b0, 1'b0, 20'h0010C, 7};
        vecs[1] = '{20'h01000, 20'd8,  32'hB0,   8,  2,  5,  1'b0, 1'b0, 20'h0101C, 16};
        vecs[2] = '{20'h02000, 20'd24, 32'h1000, 24, 1,  25, 1'b0, 1'b1, 20'h0205C, 52};
        vecs[3] = '{20'h03000, 20'd3,  32'hC0,   6,  -1, 0,  1'b0, 1'b0, 20'h03008, 6};
        vecs[4] = '{20'h03100, 20'd3,  32'hC3,   3,  -1, 0,  1'b0, 1'b0, 20'h03108, 6};
        vecs[5] = '{20'hFFFF8, 20'd4,  32'hD0,   4,  -1, 0,  1'b0, 1'b0, 20'h00004, 7};
        vecs[6] = '{20'h04000, 20'd0,  32'h0,    2,  -1, 0,  1'b0, 1'b0, 20'h00000, 1};
        vecs[7] = '{20'h05000, 20'd6,  32'hE0,   6,  -1, 0,  1'b1, 1'b0, 20'h05014, 9};

        reset = 1'b1; start = 1'b0; base_addr = '0; frame_words = '0;
        iValid = 1'b0; iData = '0; write_done = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_write", write, 1'b0);
        check("reset_addr", write_addr, 20'h0);
        check("reset_data", oData, 32'h0);
        check("reset_ready", oReady, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_done", frame_done, 1'b0);
        reset = 1'b0;
        @(negedge clk);

        for (int r = 0; r < 8; r++) begin
            run_frame($sformatf("row%0d", r), vecs[r]);
            $display("[TB] row%0d base=0x%05h words=%0d checked", r, vecs[r].base, vecs[r].words);
        end

        // Reset after two of eight writes, then a fresh frame must start clean at 0x00200.
        acc = 0;
        for (int it = 0; it < 60 && acc < 2; it++) begin
            @(negedge clk);
            start = (it == 0); base_addr = 20'h00300; frame_words = 20'd8;
            iValid = 1'b1; iData = 32'h77 + 32'(it); write_done = 1'b1;
            if (write && write_done) acc++;
        end
        check("rst_two_writes", acc, 2);
        @(negedge clk);
        reset = 1'b1; start = 1'b0; iValid = 1'b0; write_done = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        check("rst_outputs", {write, write_addr, oData, oReady, busy, frame_done}, '0);
        @(negedge clk);
        check("rst_still_idle", {write, busy}, 2'b00);
        run_frame("rst_new", '{20'h00200, 20'd4, 32'h90, 4, -1, 0, 1'b0, 1'b0, 20'h0020C, 7});
        $display("[TB] reset-mid-frame sequence checked");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
